// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared register-file constants and index type
package rv32i_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
endpackage

// File: rtl/rv32i_scoreboard.sv
// rv32i_scoreboard: per-register busy bits, set on issue and cleared on writeback
module rv32i_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_reg,
  input  logic             clr0_valid,
  input  logic [AW-1:0]    clr0_reg,
  input  logic             clr1_valid,
  input  logic [AW-1:0]    clr1_reg,
  output logic [NREGS-1:0] busy_vec
);
  logic [NREGS-1:0] set_mask, clr_mask, busy_nxt;
  always_comb begin
    set_mask = {{(NREGS-1){1'b0}}, iss_valid} << iss_reg;
    clr_mask = ({{(NREGS-1){1'b0}}, clr0_valid} << clr0_reg) | ({{(NREGS-1){1'b0}}, clr1_valid} << clr1_reg);
    // set applied after clear so a new producer outranks the retiring one; x0 never busy
    busy_nxt = ((busy_vec & ~clr_mask) | set_mask) & ~{{(NREGS-1){1'b0}}, 1'b1};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) busy_vec <= '0;
    else busy_vec <= busy_nxt;
endmodule

// File: rtl/rv32i_regfile_sb.sv
// rv32i_regfile_sb: multi-port RV32I register file with write bypass and scoreboard
module rv32i_regfile_sb
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  output logic [NRD-1:0]            rd_ready,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_reg,
  input  logic                      wb0_enable,
  input  logic [AW-1:0]             wb0_reg,
  input  logic [XLEN-1:0]           wb0_data,
  input  logic                      wb1_enable,
  input  logic [AW-1:0]             wb1_reg,
  input  logic [XLEN-1:0]           wb1_data,
  output logic [NREGS-1:0]          busy_vec
);
  logic [XLEN-1:0] regs [NREGS];
  logic wb0_act, wb1_act;
  assign wb0_act = wb0_enable && wb0_reg != '0;
  assign wb1_act = wb1_enable && wb1_reg != '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) regs <= '{default: '0};
    else begin
      if (wb0_act) regs[wb0_reg] <= wb0_data;
      if (wb1_act) regs[wb1_reg] <= wb1_data;
    end
  rv32i_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk),
    .reset_n(reset_n),
    .iss_valid(iss_valid && iss_reg != '0),
    .iss_reg(iss_reg),
    .clr0_valid(wb0_act),
    .clr0_reg(wb0_reg),
    .clr1_valid(wb1_act),
    .clr1_reg(wb1_reg),
    .busy_vec(busy_vec)
  );
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic hit0, hit1;
    assign hit0 = BYPASS != 0 && wb0_act && wb0_reg == rd_addr[i];
    assign hit1 = BYPASS != 0 && wb1_act && wb1_reg == rd_addr[i];
    // gating on reset_n keeps bypassed write data from leaking out while in reset
    assign rd_data[i] = !reset_n ? '0 : hit1 ? wb1_data : hit0 ? wb0_data : regs[rd_addr[i]];
    assign rd_ready[i] = !reset_n || rd_addr[i] == '0 || hit0 || hit1 || !busy_vec[rd_addr[i]];
  end
endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// tb_rv32i_regfile_sb: directed vector table plus async-reset sequence for rv32i_regfile_sb
module tb_rv32i_regfile_sb;
  import rv32i_pkg::*;
  typedef struct {
    logic rst_n;
    logic iss_v;
    reg_idx_t iss_r;
    logic w0e;
    reg_idx_t w0r;
    logic [31:0] w0d;
    logic w1e;
    reg_idx_t w1r;
    logic [31:0] w1d;
    reg_idx_t a0;
    reg_idx_t a1;
    logic [31:0] d0;
    logic r0;
    logic [31:0] d1;
    logic r1;
    logic [31:0] busy;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0][4:0] rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0] rd_ready;
  logic iss_valid, wb0_enable, wb1_enable;
  logic [4:0] iss_reg, wb0_reg, wb1_reg;
  logic [31:0] wb0_data, wb1_data, busy_vec;
  int checks = 0;
  int errors = 0;
  vec_t vec [14];
  always #5 clk = ~clk;
  rv32i_regfile_sb dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .wb0_enable(wb0_enable), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
    .wb1_enable(wb1_enable), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
    .busy_vec(busy_vec)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle();
    iss_valid = 0; iss_reg = 0;
    wb0_enable = 0; wb0_reg = 0; wb0_data = 0;
    wb1_enable = 0; wb1_reg = 0; wb1_data = 0;
  endtask
  initial begin
    //         rst iv ir  w0e w0r w0d           w1e w1r w1d    a0 a1  d0            r0 d1            r1 busy
    vec[0]  = '{0, 0, 0,  1, 5, 32'hAA,        0, 0, 0,       5, 0,  0,            1, 0,            1, 0};
    vec[1]  = '{1, 0, 0,  1, 3, 32'hDEADBEEF,  0, 0, 0,       3, 1,  32'hDEADBEEF, 1, 0,            1, 0};
    vec[2]  = '{1, 0, 0,  1, 0, 32'h1234,      0, 0, 0,       3, 0,  32'hDEADBEEF, 1, 0,            1, 0};
    vec[3]  = '{1, 0, 0,  0, 0, 0,             0, 0, 0,       0, 3,  0,            1, 32'hDEADBEEF, 1, 0};
    vec[4]  = '{1, 0, 0,  1, 7, 32'h11,        1, 7, 32'h22,  7, 3,  32'h22,       1, 32'hDEADBEEF, 1, 0};
    vec[5]  = '{1, 1, 9,  0, 0, 0,             0, 0, 0,       7, 9,  32'h22,       1, 0,            1, 0};
    vec[6]  = '{1, 0, 0,  0, 0, 0,             0, 0, 0,       9, 7,  0,            0, 32'h22,       1, 32'h200};
    vec[7]  = '{1, 0, 0,  1, 9, 32'h55,        0, 0, 0,       9, 7,  32'h55,       1, 32'h22,       1, 32'h200};
    vec[8]  = '{1, 1, 4,  0, 0, 0,             1, 4, 32'h99,  4, 9,  32'h99,       1, 32'h55,       1, 0};
    vec[9]  = '{1, 0, 0,  0, 0, 0,             0, 0, 0,       4, 9,  32'h99,       0, 32'h55,       1, 32'h10};
    vec[10] = '{1, 1, 2,  1, 2, 32'h77,        0, 0, 0,       2, 4,  32'h77,       1, 32'h99,       0, 32'h10};
    vec[11] = '{1, 0, 0,  1, 4, 32'hCD,        1, 4, 32'hAB,  4, 2,  32'hAB,       1, 32'h77,       0, 32'h14};
    vec[12] = '{1, 1, 0,  0, 0, 0,             0, 0, 0,       4, 2,  32'hAB,       1, 32'h77,       0, 32'h4};
    vec[13] = '{1, 0, 0,  0, 0, 0,             0, 0, 0,       0, 2,  0,            1, 32'h77,       0, 32'h4};
    idle();
    rd_addr = '0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      reset_n = vec[k].rst_n;
      iss_valid = vec[k].iss_v; iss_reg = vec[k].iss_r;
      wb0_enable = vec[k].w0e; wb0_reg = vec[k].w0r; wb0_data = vec[k].w0d;
      wb1_enable = vec[k].w1e; wb1_reg = vec[k].w1r; wb1_data = vec[k].w1d;
      rd_addr[0] = vec[k].a0; rd_addr[1] = vec[k].a1;
      @(negedge clk);
      chk($sformatf("v%0d rd_data0", k), rd_data[0], vec[k].d0);
      chk($sformatf("v%0d rd_ready0", k), {31'b0, rd_ready[0]}, {31'b0, vec[k].r0});
      chk($sformatf("v%0d rd_data1", k), rd_data[1], vec[k].d1);
      chk($sformatf("v%0d rd_ready1", k), {31'b0, rd_ready[1]}, {31'b0, vec[k].r1});
      chk($sformatf("v%0d busy_vec", k), busy_vec, vec[k].busy);
    end
    // asynchronous reset between edges while x2 is busy and holds 0x77
    @(posedge clk);
    #1;
    idle();
    rd_addr[0] = 2; rd_addr[1] = 4;
    #1;
    chk("pre-reset x2 data", rd_data[0], 32'h77);
    chk("pre-reset busy", busy_vec, 32'h4);
    reset_n = 0;
    #1;
    chk("mid-reset x2 data", rd_data[0], 32'h0);
    chk("mid-reset x2 ready", {31'b0, rd_ready[0]}, 32'h1);
    chk("mid-reset x4 data", rd_data[1], 32'h0);
    chk("mid-reset busy", busy_vec, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1;
    wb0_enable = 1; wb0_reg = 6; wb0_data = 32'h5A5A;
    iss_valid = 1; iss_reg = 8;
    rd_addr[0] = 6; rd_addr[1] = 2;
    @(negedge clk);
    chk("post-reset bypass x6", rd_data[0], 32'h5A5A);
    chk("post-reset x2 data", rd_data[1], 32'h0);
    @(posedge clk);
    #1;
    idle();
    rd_addr[1] = 8;
    #1;
    chk("first edge write x6", rd_data[0], 32'h5A5A);
    chk("first edge busy", busy_vec, 32'h100);
    chk("first edge x8 ready", {31'b0, rd_ready[1]}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
